// File: rtl/music_score_controller.sv
// music_score_controller: steps through a fixed score, holding each note for
// its length in 1 ms ticks, and presents the current note/octave/length.
module music_score_controller #(
    parameter int unsigned SCORE_LEN = 14
) (
    input  logic        clk_1ms,
    input  logic        rst,
    input  logic        en,
    output logic [7:0]  note_pointer,
    output logic [15:0] cur_length,
    output logic [3:0]  cur_note,
    output logic [3:0]  cur_octave
);

    localparam int unsigned PTR_W  = 8;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned NOTE_W = 4;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(SCORE_LEN - 1);

    typedef struct packed {
        logic [LEN_W-1:0]  length;
        logic [NOTE_W-1:0] octave;
        logic [NOTE_W-1:0] note;
    } score_entry_t;

    score_entry_t     entry;
    logic [LEN_W-1:0] ms_cnt;
    logic             note_done;

    // Score ROM lookup; entries beyond the configured length read as empty.
    always_comb begin
        entry = '0;
        case (note_pointer)
            8'd0:    entry = '{length: 16'd500,  octave: 4'd4, note: 4'd1};
            8'd1:    entry = '{length: 16'd500,  octave: 4'd4, note: 4'd1};
            8'd2:    entry = '{length: 16'd500,  octave: 4'd4, note: 4'd8};
            8'd3:    entry = '{length: 16'd500,  octave: 4'd4, note: 4'd8};
            8'd4:    entry = '{length: 16'd500,  octave: 4'd4, note: 4'd10};
            8'd5:    entry = '{length: 16'd500,  octave: 4'd4, note: 4'd10};
            8'd6:    entry = '{length: 16'd1000, octave: 4'd4, note: 4'd8};
            8'd7:    entry = '{length: 16'd500,  octave: 4'd4, note: 4'd6};
            8'd8:    entry = '{length: 16'd500,  octave: 4'd4, note: 4'd6};
            8'd9:    entry = '{length: 16'd500,  octave: 4'd4, note: 4'd5};
            8'd10:   entry = '{length: 16'd500,  octave: 4'd4, note: 4'd5};
            8'd11:   entry = '{length: 16'd500,  octave: 4'd4, note: 4'd3};
            8'd12:   entry = '{length: 16'd500,  octave: 4'd4, note: 4'd3};
            8'd13:   entry = '{length: 16'd1000, octave: 4'd4, note: 4'd1};
            default: entry = '0;
        endcase
        if ({24'd0, note_pointer} >= SCORE_LEN) begin
            entry = '0;
        end
    end

    // Decoded entry fields; a zero length still occupies one tick.
    always_comb begin
        cur_length = entry.length;
        cur_octave = entry.octave;
        cur_note   = entry.note;
        note_done  = (entry.length == '0) || (ms_cnt >= (entry.length - LEN_W'(1)));
    end

    // Elapsed-time counter and score pointer; both freeze while paused.
    always_ff @(posedge clk_1ms or negedge rst) begin
        if (!rst) begin
            ms_cnt       <= '0;
            note_pointer <= '0;
        end else if (en) begin
            if (note_done) begin
                ms_cnt       <= '0;
                note_pointer <= (note_pointer == LAST_IDX) ? '0 : note_pointer + PTR_W'(1);
            end else begin
                ms_cnt <= ms_cnt + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_music_score_controller.sv
// Directed bench for music_score_controller: default score plus a 2-entry
// instance sharing clock, reset and enable.
module tb_music_score_controller;

    logic        clk_1ms = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  note_pointer, note_pointer2;
    logic [15:0] cur_length, cur_length2;
    logic [3:0]  cur_note, cur_note2;
    logic [3:0]  cur_octave, cur_octave2;

    int checks = 0;
    int errors = 0;

    music_score_controller #(.SCORE_LEN(14)) dut (
        .clk_1ms      (clk_1ms),
        .rst          (rst),
        .en           (en),
        .note_pointer (note_pointer),
        .cur_length   (cur_length),
        .cur_note     (cur_note),
        .cur_octave   (cur_octave)
    );

    music_score_controller #(.SCORE_LEN(2)) dut2 (
        .clk_1ms      (clk_1ms),
        .rst          (rst),
        .en           (en),
        .note_pointer (note_pointer2),
        .cur_length   (cur_length2),
        .cur_note     (cur_note2),
        .cur_octave   (cur_octave2)
    );

    always #5 clk_1ms = ~clk_1ms;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_1ms);
        #1;
    endtask

    task automatic chk_entry(input string tag, input logic [7:0] p, input logic [3:0] n,
                             input logic [15:0] l);
        chk({tag, "_ptr"}, 32'(note_pointer), 32'(p));
        chk({tag, "_note"}, 32'(cur_note), 32'(n));
        chk({tag, "_oct"}, 32'(cur_octave), 32'd4);
        chk({tag, "_len"}, 32'(cur_length), 32'(l));
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        #2;
        chk_entry("rst_imm", 8'd0, 4'd1, 16'd500);
        tick(20);
        chk_entry("rst_hold", 8'd0, 4'd1, 16'd500);
        chk("rst_hold_p2", 32'(note_pointer2), 32'd0);

        // Release mid-cycle; first enabled edge is tick 1 of entry 0.
        rst = 1'b1;
        tick(499);
        chk_entry("adv_499", 8'd0, 4'd1, 16'd500);
        chk("adv_499_p2", 32'(note_pointer2), 32'd0);
        tick(1);
        chk_entry("adv_500", 8'd1, 4'd1, 16'd500);
        chk("adv_500_p2", 32'(note_pointer2), 32'd1);
        tick(500);
        chk_entry("adv_1000", 8'd2, 4'd8, 16'd500);
        chk("adv_1000_p2", 32'(note_pointer2), 32'd0);

        tick(2500);
        chk_entry("long_3500", 8'd6, 4'd8, 16'd1000);
        chk("long_3500_p2", 32'(note_pointer2), 32'd1);
        tick(499);
        chk_entry("long_3999", 8'd6, 4'd8, 16'd1000);
        tick(1);
        chk_entry("after_long", 8'd7, 4'd6, 16'd500);
        tick(3000);
        chk_entry("last_7000", 8'd13, 4'd1, 16'd1000);
        tick(999);
        chk_entry("last_7999", 8'd13, 4'd1, 16'd1000);
        tick(1);
        chk_entry("wrap_8000", 8'd0, 4'd1, 16'd500);
        chk("wrap_8000_p2", 32'(note_pointer2), 32'd0);

        // Pause holds elapsed time.
        tick(300);
        en = 1'b0;
        tick(1000);
        chk_entry("pause", 8'd0, 4'd1, 16'd500);
        chk("pause_p2", 32'(note_pointer2), 32'd0);
        en = 1'b1;
        tick(199);
        chk("resume_199", 32'(note_pointer), 32'd0);
        tick(1);
        chk("resume_200", 32'(note_pointer), 32'd1);
        chk("resume_200_p2", 32'(note_pointer2), 32'd1);

        // Mid-note reset at 1250 enabled edges into the score.
        tick(750);
        chk_entry("pre_rst", 8'd2, 4'd8, 16'd500);
        rst = 1'b0;
        #2;
        chk_entry("mid_rst", 8'd0, 4'd1, 16'd500);
        chk("mid_rst_p2", 32'(note_pointer2), 32'd0);
        tick(3);
        chk("mid_rst_hold", 32'(note_pointer), 32'd0);
        rst = 1'b1;
        tick(499);
        chk("post_rst_499", 32'(note_pointer), 32'd0);
        tick(1);
        chk_entry("post_rst_500", 8'd1, 4'd1, 16'd500);

        // Disabled edge where the note would end does not count.
        tick(499);
        chk("edge_en_pre", 32'(note_pointer), 32'd1);
        en = 1'b0;
        tick(1);
        chk("edge_en_off", 32'(note_pointer), 32'd1);
        en = 1'b1;
        tick(1);
        chk("edge_en_on", 32'(note_pointer), 32'd2);
        chk("edge_en_on_p2", 32'(note_pointer2), 32'd0);
        tick(500);
        chk("p2_period", 32'(note_pointer2), 32'd1);
        chk("p2_len", 32'(cur_length2), 32'd500);
        chk("p2_note", 32'(cur_note2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
